// File: rtl/opl3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : opl3_pkg
//  Description : Shared sizing constants and enumerations for the OPL3
//                operator datapath (bank/operator geometry, output width,
//                modulation source selector, modulation_calc FSM states).
//  Revision    : 1.0  initial release
// ============================================================================
package opl3_pkg;

    localparam int NUM_BANKS              = 2;
    localparam int NUM_OPERATORS_PER_BANK = 18;
    localparam int OP_OUT_WIDTH           = 13;
    localparam int BANK_NUM_WIDTH         = $clog2(NUM_BANKS);
    localparam int OP_NUM_WIDTH           = $clog2(NUM_OPERATORS_PER_BANK);
    localparam int REG_FB_WIDTH           = 3;

    // Source of the phase-modulation term for the next operator slot.
    typedef enum logic [1:0] {
        MOD_SRC_NONE = 2'd0,  // additive: no modulation
        MOD_SRC_PREV = 2'd1,  // FM from previous operator of the channel
        MOD_SRC_FB   = 2'd2,  // self-feedback
        MOD_SRC_RSVD = 2'd3   // reserved, behaves like NONE
    } mod_src_t;

    // History clear sweep / steady state.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } calc_state_t;

endpackage : opl3_pkg
`default_nettype wire

// File: rtl/feedback_scale.sv
`default_nettype none
// ============================================================================
//  Module      : feedback_scale
//  Description : Combinational self-feedback scaler. Sums the two most recent
//                outputs of an operator (14-bit signed), arithmetically shifts
//                right by (9 - fb) and truncates to the operator width.
//                fb = 0 disables feedback (result 0).
//  Ports       : i_d1  - latest operator output (signed)
//                i_d2  - previous operator output (signed)
//                i_fb  - feedback level 0..7
//                o_mod - scaled feedback modulation (signed)
//  Revision    : 1.0  initial release
// ============================================================================
module feedback_scale
    import opl3_pkg::*;
(
    input  logic signed [OP_OUT_WIDTH-1:0] i_d1,
    input  logic signed [OP_OUT_WIDTH-1:0] i_d2,
    input  logic        [REG_FB_WIDTH-1:0] i_fb,
    output logic signed [OP_OUT_WIDTH-1:0] o_mod
);

    logic signed [OP_OUT_WIDTH:0] w_sum;
    logic signed [OP_OUT_WIDTH:0] w_shifted;
    logic        [3:0]            w_shamt;

    // One extra bit of headroom so the sum of two full-scale samples fits.
    assign w_sum     = {i_d1[OP_OUT_WIDTH-1], i_d1} + {i_d2[OP_OUT_WIDTH-1], i_d2};
    assign w_shamt   = 4'd9 - {1'b0, i_fb};
    // Shift is at least 2 for fb >= 1, so dropping the top bit cannot overflow.
    assign w_shifted = w_sum >>> w_shamt;
    assign o_mod     = (i_fb == '0) ? '0 : w_shifted[OP_OUT_WIDTH-1:0];

endmodule : feedback_scale
`default_nettype wire

// File: rtl/modulation_calc.sv
`default_nettype none
// ============================================================================
//  Module      : modulation_calc
//  Description : Operator back end. Keeps a two-deep output history per
//                (bank, operator) and produces the phase-modulation term for
//                the next operator slot: none, previous operator (FM) or
//                self-feedback. History is cleared by a sweep after reset.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                wr_en_p6/wr_bank_p6/wr_op_p6/op_out_p6 - output write port
//                rd_en_p0/bank_num/op_num/mod_src_p0/prev_op_num/fb
//                                   - modulation request
//                modulation_p1      - modulation term, 1 cycle after request
//                ready              - clear sweep complete
//  Revision    : 1.0  initial release
// ============================================================================
module modulation_calc
    import opl3_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en_p6,
    input  logic [BANK_NUM_WIDTH-1:0] wr_bank_p6,
    input  logic [OP_NUM_WIDTH-1:0]   wr_op_p6,
    input  logic [OP_OUT_WIDTH-1:0]   op_out_p6,
    input  logic                      rd_en_p0,
    input  logic [BANK_NUM_WIDTH-1:0] bank_num,
    input  logic [OP_NUM_WIDTH-1:0]   op_num,
    input  logic [1:0]                mod_src_p0,
    input  logic [OP_NUM_WIDTH-1:0]   prev_op_num,
    input  logic [REG_FB_WIDTH-1:0]   fb,
    output logic [OP_OUT_WIDTH-1:0]   modulation_p1,
    output logic                      ready
);

    localparam logic [OP_NUM_WIDTH-1:0] c_num_ops = OP_NUM_WIDTH'(NUM_OPERATORS_PER_BANK);
    localparam logic [OP_NUM_WIDTH-1:0] c_last_op = OP_NUM_WIDTH'(NUM_OPERATORS_PER_BANK - 1);

    calc_state_t               r_state;
    logic [OP_NUM_WIDTH-1:0]   r_clr_idx;
    logic                      r_ready;
    logic [OP_OUT_WIDTH-1:0]   r_mod;

    logic signed [OP_OUT_WIDTH-1:0] r_d1 [NUM_BANKS][NUM_OPERATORS_PER_BANK];
    logic signed [OP_OUT_WIDTH-1:0] r_d2 [NUM_BANKS][NUM_OPERATORS_PER_BANK];

    logic                           w_wr_valid;
    logic [OP_NUM_WIDTH-1:0]        w_rd_op;
    logic                           w_rd_in_range;
    logic                           w_fwd;
    logic signed [OP_OUT_WIDTH-1:0] w_d1_rd;
    logic signed [OP_OUT_WIDTH-1:0] w_d2_rd;
    logic signed [OP_OUT_WIDTH-1:0] w_fb_mod;
    logic [OP_OUT_WIDTH-1:0]        w_mod_next;

    // ------------------------------------------------------------------
    // Clear sweep FSM. ready is registered from the state, so it rises
    // one edge after RUN is entered (19th edge after reset release).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_ready <= (r_state == ST_RUN);
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_idx == c_last_op) begin
                        r_state   <= ST_RUN;
                        r_clr_idx <= '0;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // History storage. No reset here: the sweep is what zeroes it.
    // ------------------------------------------------------------------
    assign w_wr_valid = (r_state == ST_RUN) && wr_en_p6 && (wr_op_p6 < c_num_ops);

    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_d1[b][r_clr_idx] <= '0;
                r_d2[b][r_clr_idx] <= '0;
            end
        end else if (w_wr_valid) begin
            r_d2[wr_bank_p6][wr_op_p6] <= r_d1[wr_bank_p6][wr_op_p6];
            r_d1[wr_bank_p6][wr_op_p6] <= op_out_p6;
        end
    end

    // ------------------------------------------------------------------
    // Read path with write-first forwarding: a same-cycle write to the
    // entry being read is presented as if it had already committed.
    // ------------------------------------------------------------------
    assign w_rd_op       = (mod_src_p0 == MOD_SRC_PREV) ? prev_op_num : op_num;
    assign w_rd_in_range = (op_num < c_num_ops) && (w_rd_op < c_num_ops);
    assign w_fwd         = w_wr_valid && (wr_bank_p6 == bank_num) && (wr_op_p6 == w_rd_op);
    assign w_d1_rd       = w_fwd ? op_out_p6 : r_d1[bank_num][w_rd_op];
    assign w_d2_rd       = w_fwd ? r_d1[bank_num][w_rd_op] : r_d2[bank_num][w_rd_op];

    feedback_scale u_feedback_scale (
        .i_d1  (w_d1_rd),
        .i_d2  (w_d2_rd),
        .i_fb  (fb),
        .o_mod (w_fb_mod)
    );

    always_comb begin
        w_mod_next = '0;
        if ((r_state == ST_RUN) && w_rd_in_range) begin
            case (mod_src_t'(mod_src_p0))
                MOD_SRC_PREV: w_mod_next = w_d1_rd;
                MOD_SRC_FB:   w_mod_next = w_fb_mod;
                default:      w_mod_next = '0;
            endcase
        end
    end

    // Output holds between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mod <= '0;
        end else if (rd_en_p0) begin
            r_mod <= w_mod_next;
        end
    end

    assign modulation_p1 = r_mod;
    assign ready         = r_ready;

endmodule : modulation_calc
`default_nettype wire

// File: tb/tb_modulation_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modulation_calc
//  Description : Self-checking bench for modulation_calc. A behavioural model
//                tracks history and expected outputs per clock; a compare
//                process checks every cycle, and directed vectors carry
//                hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_modulation_calc;
    import opl3_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      wr_en_p6 = 1'b0;
    logic [BANK_NUM_WIDTH-1:0] wr_bank_p6 = '0;
    logic [OP_NUM_WIDTH-1:0]   wr_op_p6 = '0;
    logic [OP_OUT_WIDTH-1:0]   op_out_p6 = '0;
    logic                      rd_en_p0 = 1'b0;
    logic [BANK_NUM_WIDTH-1:0] bank_num = '0;
    logic [OP_NUM_WIDTH-1:0]   op_num = '0;
    logic [1:0]                mod_src_p0 = '0;
    logic [OP_NUM_WIDTH-1:0]   prev_op_num = '0;
    logic [REG_FB_WIDTH-1:0]   fb = '0;
    logic [OP_OUT_WIDTH-1:0]   modulation_p1;
    logic                      ready;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    modulation_calc dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en_p6      (wr_en_p6),
        .wr_bank_p6    (wr_bank_p6),
        .wr_op_p6      (wr_op_p6),
        .op_out_p6     (op_out_p6),
        .rd_en_p0      (rd_en_p0),
        .bank_num      (bank_num),
        .op_num        (op_num),
        .mod_src_p0    (mod_src_p0),
        .prev_op_num   (prev_op_num),
        .fb            (fb),
        .modulation_p1 (modulation_p1),
        .ready         (ready)
    );

    // ------------------------------------------------------------------
    // Behavioural model: integer history, write applied before the read
    // (write-first), feedback computed with plain signed arithmetic.
    // ------------------------------------------------------------------
    int                      m_d1 [NUM_BANKS][NUM_OPERATORS_PER_BANK];
    int                      m_d2 [NUM_BANKS][NUM_OPERATORS_PER_BANK];
    int                      m_edges = 0;
    bit                      m_run;
    int                      m_sum;
    int                      m_res;
    logic [OP_OUT_WIDTH-1:0] exp_mod = '0;
    logic                    exp_ready = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edges = 0;
            for (int b = 0; b < NUM_BANKS; b++)
                for (int o = 0; o < NUM_OPERATORS_PER_BANK; o++) begin
                    m_d1[b][o] = 0;
                    m_d2[b][o] = 0;
                end
            exp_mod   = '0;
            exp_ready = 1'b0;
        end else begin
            if (m_edges < 1000) m_edges++;
            // The sweep needs 18 edges; the 19th edge is the first in service.
            m_run = (m_edges >= NUM_OPERATORS_PER_BANK + 1);
            if (m_run && wr_en_p6 && (int'(wr_op_p6) < NUM_OPERATORS_PER_BANK)) begin
                m_d2[wr_bank_p6][wr_op_p6] = m_d1[wr_bank_p6][wr_op_p6];
                m_d1[wr_bank_p6][wr_op_p6] = $signed(op_out_p6);
            end
            if (rd_en_p0) begin
                m_res = 0;
                if (m_run && (int'(op_num) < NUM_OPERATORS_PER_BANK)) begin
                    if (mod_src_p0 == 2'd1) begin
                        if (int'(prev_op_num) < NUM_OPERATORS_PER_BANK)
                            m_res = m_d1[bank_num][prev_op_num];
                    end else if (mod_src_p0 == 2'd2 && fb != 0) begin
                        m_sum = m_d1[bank_num][op_num] + m_d2[bank_num][op_num];
                        m_res = m_sum >>> (9 - int'(fb));
                    end
                end
                exp_mod = m_res[OP_OUT_WIDTH-1:0];
            end
            exp_ready = m_run;
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if (modulation_p1 !== exp_mod) begin
            n_fail++;
            $display("FAIL model_mod t=%0t got=%h expected=%h", $time, modulation_p1, exp_mod);
        end
        n_cmp++;
        if (ready !== exp_ready) begin
            n_fail++;
            $display("FAIL model_ready t=%0t got=%b expected=%b", $time, ready, exp_ready);
        end
    end

    // ------------------------------------------------------------------
    // Literal checks and stimulus helpers
    // ------------------------------------------------------------------
    task automatic chk_mod(input string name, input logic [OP_OUT_WIDTH-1:0] exp);
        n_cmp++;
        if (modulation_p1 !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, modulation_p1, exp);
        end
    endtask

    task automatic chk_rdy(input string name, input logic exp);
        n_cmp++;
        if (ready !== exp) begin
            n_fail++;
            $display("FAIL %s ready got=%b expected=%b", name, ready, exp);
        end
    endtask

    // One clock: drive both ports, wait past the edge, then idle them.
    task automatic cyc(input logic we, input int wb, input int wo, input int wv,
                       input logic re, input int rb, input int ro, input int rs,
                       input int rp, input int rf);
        wr_en_p6    = we;
        wr_bank_p6  = BANK_NUM_WIDTH'(wb);
        wr_op_p6    = OP_NUM_WIDTH'(wo);
        op_out_p6   = OP_OUT_WIDTH'(wv);
        rd_en_p0    = re;
        bank_num    = BANK_NUM_WIDTH'(rb);
        op_num      = OP_NUM_WIDTH'(ro);
        mod_src_p0  = 2'(rs);
        prev_op_num = OP_NUM_WIDTH'(rp);
        fb          = REG_FB_WIDTH'(rf);
        @(posedge clk);
        #1;
        wr_en_p6 = 1'b0;
        rd_en_p0 = 1'b0;
    endtask

    task automatic wr(input int b, input int o, input int v);
        cyc(1'b1, b, o, v, 1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int b, input int o, input int s, input int p, input int f);
        cyc(1'b0, 0, 0, 0, 1'b1, b, o, s, p, f);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_mod("reset_mod", 13'h0000);
        chk_rdy("reset_ready", 1'b0);

        // Release reset, then 18 sweep cycles: reads return 0, write dropped.
        rst_n = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            cyc(k == 5, 0, 2, 13'h0555, 1'b1, k % 2, k % 18, 2, 0, 7);
            chk_mod("clear_read_zero", 13'h0000);
            chk_rdy("clear_ready_low", 1'b0);
        end
        rd(0, 2, 1, 2, 0);
        chk_rdy("ready_rises_edge19", 1'b1);
        chk_mod("clear_write_dropped", 13'h0000);

        // FM source
        wr(0, 3, 13'h0123);
        rd(0, 6, 1, 3, 0);
        chk_mod("fm_prev_op", 13'h0123);

        // Self-feedback: 100 then 300
        wr(0, 0, 100);
        wr(0, 0, 300);
        rd(0, 0, 2, 0, 7);
        chk_mod("fb7_sum400", 13'd100);
        idle(2);
        chk_mod("hold_without_rd", 13'd100);
        rd(0, 0, 2, 0, 1);
        chk_mod("fb1_sum400", 13'd1);
        rd(0, 0, 2, 0, 0);
        chk_mod("fb0_zero", 13'd0);

        // Negative feedback: -4096, -4095
        wr(0, 1, 13'h1000);
        wr(0, 1, 13'h1001);
        rd(0, 1, 2, 0, 7);
        chk_mod("fb7_negative", 13'h1800);

        // Collisions
        wr(0, 5, 10);
        cyc(1'b1, 0, 5, 50, 1'b1, 0, 5, 2, 0, 6);
        chk_mod("collision_fb6", 13'd7);
        cyc(1'b1, 0, 5, 77, 1'b1, 0, 5, 1, 5, 0);
        chk_mod("collision_prev", 13'd77);

        // Bank isolation
        wr(1, 0, 13'h0AAA);
        rd(0, 0, 1, 0, 0);
        chk_mod("bank0_isolated", 13'd300);
        rd(1, 0, 1, 0, 0);
        chk_mod("bank1_written", 13'h0AAA);

        // Out of range and reserved source
        wr(0, 20, 5);
        rd(0, 20, 2, 0, 7);
        chk_mod("oor_op_read", 13'd0);
        rd(0, 0, 1, 0, 0);
        chk_mod("reload_nonzero", 13'd300);
        rd(0, 0, 1, 20, 0);
        chk_mod("oor_prev_read", 13'd0);
        rd(0, 4, 1, 4, 0);
        chk_mod("oor_write_no_alias", 13'd0);
        rd(0, 0, 1, 0, 0);
        rd(0, 0, 3, 0, 7);
        chk_mod("reserved_src", 13'd0);

        // Mixed traffic, checked by the model every cycle
        for (int i = 0; i < 40; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom_range(0, 19),
                $urandom_range(0, 8191), 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                $urandom_range(0, 19), $urandom_range(0, 3), $urandom_range(0, 19),
                $urandom_range(0, 7));
        end

        // Reset in the middle of RUN
        wr(0, 0, 13'h00FF);
        rd(0, 0, 1, 0, 0);
        chk_mod("pre_reset_value", 13'h00FF);
        rst_n = 1'b0;
        idle(2);
        chk_mod("midrun_reset_mod", 13'd0);
        chk_rdy("midrun_reset_ready", 1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            idle(1);
            chk_rdy("reclear_ready_low", 1'b0);
        end
        rd(0, 0, 1, 0, 0);
        chk_rdy("reclear_ready_high", 1'b1);
        chk_mod("reclear_history_d1", 13'd0);
        rd(0, 5, 2, 0, 7);
        chk_mod("reclear_history_fb", 13'd0);
        rd(1, 0, 1, 0, 0);
        chk_mod("reclear_bank1", 13'd0);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_modulation_calc
`default_nettype wire
